// File: rtl/blob_stats.sv
// blob_stats: per-label blob statistics accumulator and reporter.
// Accumulates area, bounding box and coordinate sums for each CCL label
// during a frame, then walks the table and emits one record per blob whose
// area reaches MIN_AREA, followed by a one-cycle done pulse.
module blob_stats #(
  parameter int MAX_LABELS = 16,
  parameter int MIN_AREA   = 50
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [15:0] label_in,
  input  logic        valid_in,
  input  logic        frame_done_in,
  input  logic        blob_ready_in,
  output logic        blob_valid_out,
  output logic [15:0] blob_label_out,
  output logic [16:0] blob_area_out,
  output logic [10:0] blob_xmin_out,
  output logic [10:0] blob_xmax_out,
  output logic [9:0]  blob_ymin_out,
  output logic [9:0]  blob_ymax_out,
  output logic [27:0] blob_sumx_out,
  output logic [26:0] blob_sumy_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [7:0]  num_blobs_out,
  output logic        overflow_out
);

  localparam int IW = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;
  localparam logic [16:0]   MAX_LBL  = 17'(MAX_LABELS);
  localparam logic [16:0]   MIN_A    = 17'(MIN_AREA);
  localparam logic [16:0]   AREA_SAT = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_LABELS - 1);
  localparam logic [IW-1:0] FIRST_IDX = IW'(1);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [7:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    num_blobs_q, num_blobs_d;
  logic          overflow_q, overflow_d;

  // Read-side view of the table, one element per label.
  logic [16:0] area_rd [MAX_LABELS];
  logic [10:0] xmin_rd [MAX_LABELS];
  logic [10:0] xmax_rd [MAX_LABELS];
  logic [9:0]  ymin_rd [MAX_LABELS];
  logic [9:0]  ymax_rd [MAX_LABELS];
  logic [27:0] sumx_rd [MAX_LABELS];
  logic [26:0] sumy_rd [MAX_LABELS];

  logic in_accum;
  logic pix_ok;
  logic pix_ovf;
  logic clear_tbl;

  // Pixels are only taken while accumulating; label 0 is background.
  assign in_accum  = (state_q == S_ACCUM);
  assign pix_ok    = in_accum && valid_in && (label_in != 16'd0) &&
                     ({1'b0, label_in} < MAX_LBL);
  assign pix_ovf   = in_accum && valid_in && ({1'b0, label_in} >= MAX_LBL);
  assign clear_tbl = (state_q == S_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LABELS; gi++) begin : g_entry
      logic [16:0] area_q, area_d;
      logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
      logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
      logic [27:0] sumx_q, sumx_d;
      logic [26:0] sumy_q, sumy_d;
      logic        hit;

      assign hit = pix_ok && (label_in == 16'(gi));

      // Entry update: an empty entry (area 0) is seeded by its first pixel.
      always_comb begin
        area_d = area_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        sumx_d = sumx_q;
        sumy_d = sumy_q;
        if (clear_tbl) begin
          area_d = '0;
          xmin_d = '0;
          xmax_d = '0;
          ymin_d = '0;
          ymax_d = '0;
          sumx_d = '0;
          sumy_d = '0;
        end else if (hit) begin
          if (area_q == 17'd0) begin
            area_d = 17'd1;
            xmin_d = x_in;
            xmax_d = x_in;
            ymin_d = y_in;
            ymax_d = y_in;
            sumx_d = 28'(x_in);
            sumy_d = 27'(y_in);
          end else begin
            if (area_q != AREA_SAT) begin
              area_d = area_q + 17'd1;
            end
            if (x_in < xmin_q) xmin_d = x_in;
            if (x_in > xmax_q) xmax_d = x_in;
            if (y_in < ymin_q) ymin_d = y_in;
            if (y_in > ymax_q) ymax_d = y_in;
            sumx_d = sumx_q + 28'(x_in);
            sumy_d = sumy_q + 27'(y_in);
          end
        end
      end

      // Entry storage, cleared by reset.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          area_q <= '0;
          xmin_q <= '0;
          xmax_q <= '0;
          ymin_q <= '0;
          ymax_q <= '0;
          sumx_q <= '0;
          sumy_q <= '0;
        end else begin
          area_q <= area_d;
          xmin_q <= xmin_d;
          xmax_q <= xmax_d;
          ymin_q <= ymin_d;
          ymax_q <= ymax_d;
          sumx_q <= sumx_d;
          sumy_q <= sumy_d;
        end
      end

      assign area_rd[gi] = area_q;
      assign xmin_rd[gi] = xmin_q;
      assign xmax_rd[gi] = xmax_q;
      assign ymin_rd[gi] = ymin_q;
      assign ymax_rd[gi] = ymax_q;
      assign sumx_rd[gi] = sumx_q;
      assign sumy_rd[gi] = sumy_q;
    end
  endgenerate

  // Control FSM: accumulate, scan the table, emit qualifying blobs, finish.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    num_blobs_d = num_blobs_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_ACCUM: begin
        ovf_d = ovf_q | pix_ovf;
        if (frame_done_in) begin
          state_d = S_SCAN;
          index_d = FIRST_IDX;
        end
      end
      S_SCAN: begin
        if (area_rd[index_q] >= MIN_A) begin
          state_d = S_EMIT;
        end else if (index_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + FIRST_IDX;
        end
      end
      S_EMIT: begin
        if (blob_ready_in) begin
          count_d = count_q + 8'd1;
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + FIRST_IDX;
            state_d = S_SCAN;
          end
        end
      end
      default: begin
        num_blobs_d = count_q;
        overflow_d  = ovf_q;
        count_d     = '0;
        ovf_d       = 1'b0;
        index_d     = '0;
        state_d     = S_ACCUM;
      end
    endcase
  end

  // Control registers, cleared by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_ACCUM;
      index_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      num_blobs_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      num_blobs_q <= num_blobs_d;
      overflow_q  <= overflow_d;
    end
  end

  // Record outputs are a gated view of the current entry; the table is
  // frozen outside ACCUM so the record is stable until accepted.
  always_comb begin
    blob_valid_out = (state_q == S_EMIT);
    blob_label_out = '0;
    blob_area_out  = '0;
    blob_xmin_out  = '0;
    blob_xmax_out  = '0;
    blob_ymin_out  = '0;
    blob_ymax_out  = '0;
    blob_sumx_out  = '0;
    blob_sumy_out  = '0;
    if (state_q == S_EMIT) begin
      blob_label_out = 16'(index_q);
      blob_area_out  = area_rd[index_q];
      blob_xmin_out  = xmin_rd[index_q];
      blob_xmax_out  = xmax_rd[index_q];
      blob_ymin_out  = ymin_rd[index_q];
      blob_ymax_out  = ymax_rd[index_q];
      blob_sumx_out  = sumx_rd[index_q];
      blob_sumy_out  = sumy_rd[index_q];
    end
  end

  assign busy_out      = !in_accum;
  assign done_out      = (state_q == S_DONE);
  assign num_blobs_out = num_blobs_q;
  assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_blob_stats.sv
// tb_blob_stats: scenario tasks drive frames; expected blob records are
// queued from a small table model and checked as the DUT emits them.
module tb_blob_stats;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [15:0] label_in;
  logic        valid_in;
  logic        frame_done_in;
  logic        blob_ready_in;
  logic        blob_valid_out;
  logic [15:0] blob_label_out;
  logic [16:0] blob_area_out;
  logic [10:0] blob_xmin_out, blob_xmax_out;
  logic [9:0]  blob_ymin_out, blob_ymax_out;
  logic [27:0] blob_sumx_out;
  logic [26:0] blob_sumy_out;
  logic        busy_out;
  logic        done_out;
  logic [7:0]  num_blobs_out;
  logic        overflow_out;

  always #5 clk_in = ~clk_in;

  blob_stats dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_in), .y_in(y_in),
    .label_in(label_in), .valid_in(valid_in), .frame_done_in(frame_done_in),
    .blob_ready_in(blob_ready_in), .blob_valid_out(blob_valid_out),
    .blob_label_out(blob_label_out), .blob_area_out(blob_area_out),
    .blob_xmin_out(blob_xmin_out), .blob_xmax_out(blob_xmax_out),
    .blob_ymin_out(blob_ymin_out), .blob_ymax_out(blob_ymax_out),
    .blob_sumx_out(blob_sumx_out), .blob_sumy_out(blob_sumy_out),
    .busy_out(busy_out), .done_out(done_out),
    .num_blobs_out(num_blobs_out), .overflow_out(overflow_out)
  );

  typedef struct {
    logic [15:0] label;
    logic [16:0] area;
    logic [10:0] xmin, xmax;
    logic [9:0]  ymin, ymax;
    logic [27:0] sumx;
    logic [26:0] sumy;
  } rec_t;

  rec_t exp_q[$];

  int m_area [16];
  int m_xmin [16];
  int m_xmax [16];
  int m_ymin [16];
  int m_ymax [16];
  int m_sumx [16];
  int m_sumy [16];

  int n_checks = 0;
  int n_fail   = 0;
  int first_valid_lat;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_area[i] = 0; m_xmin[i] = 0; m_xmax[i] = 0;
      m_ymin[i] = 0; m_ymax[i] = 0; m_sumx[i] = 0; m_sumy[i] = 0;
    end
  endtask

  // Drive one pixel for one cycle (optionally with frame_done) and model it.
  task automatic pix(input int x, input int y, input int l, input bit fd);
    x_in = 11'(x); y_in = 10'(y); label_in = 16'(l);
    valid_in = 1'b1; frame_done_in = fd;
    if (l > 0 && l < 16) begin
      if (m_area[l] == 0) begin
        m_xmin[l] = x; m_xmax[l] = x; m_ymin[l] = y; m_ymax[l] = y;
      end else begin
        if (x < m_xmin[l]) m_xmin[l] = x;
        if (x > m_xmax[l]) m_xmax[l] = x;
        if (y < m_ymin[l]) m_ymin[l] = y;
        if (y > m_ymax[l]) m_ymax[l] = y;
      end
      m_area[l] = m_area[l] + 1;
      m_sumx[l] = m_sumx[l] + x;
      m_sumy[l] = m_sumy[l] + y;
    end
    @(negedge clk_in);
    valid_in = 1'b0; frame_done_in = 1'b0;
  endtask

  task automatic box(input int x0, input int y0, input int w, input int h, input int l);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        pix(xx, yy, l, 1'b0);
  endtask

  // Queue the records the model says should be reported, in label order.
  task automatic push_expected();
    rec_t r;
    for (int l = 1; l < 16; l++) begin
      if (m_area[l] >= 50) begin
        r.label = 16'(l); r.area = 17'(m_area[l]);
        r.xmin = 11'(m_xmin[l]); r.xmax = 11'(m_xmax[l]);
        r.ymin = 10'(m_ymin[l]); r.ymax = 10'(m_ymax[l]);
        r.sumx = 28'(m_sumx[l]); r.sumy = 27'(m_sumy[l]);
        exp_q.push_back(r);
      end
    end
  endtask

  // End a frame and consume its records; hold = cycles of ready low
  // (with stability checks) once the first record appears.
  task automatic drain(input bit send_fd, input int hold, input int exp_num, input bit exp_ovf);
    int cyc;
    int hold_left;
    bit seen_done;
    rec_t e;
    hold_left = hold;
    seen_done = 1'b0;
    first_valid_lat = -1;
    cyc = 0;
    blob_ready_in = (hold == 0);
    if (send_fd) begin
      frame_done_in = 1'b1;
      @(negedge clk_in);
      frame_done_in = 1'b0;
      cyc = 1;
    end
    for (int k = 0; k < 400 && !seen_done; k++) begin
      if (blob_valid_out && first_valid_lat < 0) first_valid_lat = cyc;
      if (blob_valid_out && !blob_ready_in) begin
        if (hold_left > 0) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL hold_unexpected: got label %0d, required no record", blob_label_out);
          end else if ({blob_label_out, blob_area_out, blob_xmin_out, blob_xmax_out,
                        blob_ymin_out, blob_ymax_out, blob_sumx_out, blob_sumy_out} !==
                       {exp_q[0].label, exp_q[0].area, exp_q[0].xmin, exp_q[0].xmax,
                        exp_q[0].ymin, exp_q[0].ymax, exp_q[0].sumx, exp_q[0].sumy}) begin
            n_fail++;
            $display("FAIL hold_stable: got label %0d area %0d, required label %0d area %0d",
                     blob_label_out, blob_area_out, exp_q[0].label, exp_q[0].area);
          end
          hold_left--;
        end else begin
          blob_ready_in = 1'b1;
        end
      end
      if (blob_valid_out && blob_ready_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rec_unexpected: got label %0d area %0d, required none", blob_label_out, blob_area_out);
        end else begin
          e = exp_q.pop_front();
          if (blob_label_out !== e.label || blob_area_out !== e.area) begin
            n_fail++;
            $display("FAIL rec_label_area: got %0d/%0d, required %0d/%0d",
                     blob_label_out, blob_area_out, e.label, e.area);
          end
          n_checks++;
          if ({blob_xmin_out, blob_xmax_out, blob_ymin_out, blob_ymax_out} !==
              {e.xmin, e.xmax, e.ymin, e.ymax}) begin
            n_fail++;
            $display("FAIL rec_bbox: got x %0d..%0d y %0d..%0d, required x %0d..%0d y %0d..%0d",
                     blob_xmin_out, blob_xmax_out, blob_ymin_out, blob_ymax_out,
                     e.xmin, e.xmax, e.ymin, e.ymax);
          end
          n_checks++;
          if (blob_sumx_out !== e.sumx || blob_sumy_out !== e.sumy) begin
            n_fail++;
            $display("FAIL rec_sums: got %0d/%0d, required %0d/%0d",
                     blob_sumx_out, blob_sumy_out, e.sumx, e.sumy);
          end
          $display("record label %0d area %0d x %0d..%0d y %0d..%0d sums %0d/%0d",
                   blob_label_out, blob_area_out, blob_xmin_out, blob_xmax_out,
                   blob_ymin_out, blob_ymax_out, blob_sumx_out, blob_sumy_out);
        end
      end
      if (done_out) seen_done = 1'b1;
      else begin
        @(negedge clk_in);
        cyc++;
      end
    end
    n_checks++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done_out, required done_out within 400 cycles");
    end
    @(negedge clk_in);
    blob_ready_in = 1'b0;
    n_checks++;
    if (num_blobs_out !== 8'(exp_num) || overflow_out !== exp_ovf) begin
      n_fail++;
      $display("FAIL frame_summary: got num %0d ovf %0b, required num %0d ovf %0b",
               num_blobs_out, overflow_out, exp_num, exp_ovf);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_records: got %0d unreported, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("frame end: num_blobs %0d overflow %0b", num_blobs_out, overflow_out);
    model_clear();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; valid_in = 1'b0; frame_done_in = 1'b0; blob_ready_in = 1'b0;
    x_in = '0; y_in = '0; label_in = '0;
    model_clear();
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({blob_valid_out, busy_out, done_out, num_blobs_out, overflow_out, blob_area_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid %0b busy %0b done %0b num %0d ovf %0b, required all 0",
               blob_valid_out, busy_out, done_out, num_blobs_out, overflow_out);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    $display("reset released");
  endtask

  task automatic test_single_blob();
    rec_t r;
    box(100, 20, 10, 6, 3);
    model_clear();
    r.label = 16'd3; r.area = 17'd60; r.xmin = 11'd100; r.xmax = 11'd109;
    r.ymin = 10'd20; r.ymax = 10'd25; r.sumx = 28'd6270; r.sumy = 27'd1350;
    exp_q.push_back(r);
    drain(1'b1, 0, 1, 1'b0);
    n_checks++;
    if (first_valid_lat !== 4) begin
      n_fail++;
      $display("FAIL first_latency: got %0d cycles, required 4", first_valid_lat);
    end
  endtask

  task automatic test_threshold();
    box(10, 10, 7, 7, 2);
    box(50, 40, 10, 5, 5);
    push_expected();
    drain(1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    box(200, 100, 10, 5, 4);
    box(30, 150, 12, 5, 9);
    push_expected();
    drain(1'b1, 10, 2, 1'b0);
  endtask

  task automatic test_overflow();
    pix(10, 10, 20, 1'b0);
    push_expected();
    drain(1'b1, 0, 0, 1'b1);
    box(0, 0, 25, 2, 6);
    push_expected();
    drain(1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_emit();
    bit got_valid;
    box(60, 60, 10, 6, 1);
    model_clear();
    blob_ready_in = 1'b0;
    frame_done_in = 1'b1;
    @(negedge clk_in);
    frame_done_in = 1'b0;
    got_valid = 1'b0;
    for (int k = 0; k < 50 && !got_valid; k++) begin
      if (blob_valid_out) got_valid = 1'b1;
      else @(negedge clk_in);
    end
    n_checks++;
    if (!got_valid) begin
      n_fail++;
      $display("FAIL emit_timeout: got no blob_valid_out, required one within 50 cycles");
    end
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if (blob_valid_out !== 1'b0 || busy_out !== 1'b0 || blob_area_out !== '0 || num_blobs_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_emit: got valid %0b busy %0b area %0d num %0d, required all 0",
               blob_valid_out, busy_out, blob_area_out, num_blobs_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    box(5, 5, 11, 5, 1);
    push_expected();
    drain(1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_same_cycle_and_busy();
    for (int i = 0; i < 49; i++) pix(i, 5, 7, 1'b0);
    pix(49, 5, 7, 1'b1);
    push_expected();
    model_clear();
    for (int k = 0; k < 5; k++) begin
      x_in = 11'd300; y_in = 10'd170; label_in = 16'd7;
      valid_in = 1'b1; frame_done_in = 1'b1;
      n_checks++;
      if (busy_out !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_scan: got %0b, required 1", busy_out);
      end
      @(negedge clk_in);
    end
    valid_in = 1'b0; frame_done_in = 1'b0;
    drain(1'b0, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_blob();
    test_threshold();
    test_back_to_back();
    test_overflow();
    test_reset_mid_emit();
    test_same_cycle_and_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blob_stats.md
BLOB_STATS -- requirements
Module: blob_stats

Interface
REQ-001 SHALL have parameter MAX_LABELS, default 16, number of table entries; label 0 is background.
REQ-002 SHALL have parameter MIN_AREA, default 50, minimum pixel count for a blob to be reported.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have port x_in  input  11  pixel column of the labelled pixel.
REQ-006 SHALL have port y_in  input  10  pixel row of the labelled pixel.
REQ-007 SHALL have port label_in  input  16  resolved (second-pass) CCL label.
REQ-008 SHALL have port valid_in  input  1  x_in/y_in/label_in qualifier.
REQ-009 SHALL have port frame_done_in  input  1  one-cycle pulse after the last pixel of a frame.
REQ-010 SHALL have port blob_ready_in  input  1  downstream accepts the blob record.
REQ-011 SHALL have port blob_valid_out  output  1  blob record valid.
REQ-012 SHALL have port blob_label_out  output  16  label of the reported blob.
REQ-013 SHALL have port blob_area_out  output  17  pixel count.
REQ-014 SHALL have ports blob_xmin_out/blob_xmax_out  output  11 each  and blob_ymin_out/blob_ymax_out  output  10 each  bounding box.
REQ-015 SHALL have ports blob_sumx_out  output  28  and blob_sumy_out  output  27  coordinate sums for the centroid.
REQ-016 SHALL have port busy_out  output  1  high outside ACCUM; upstream holds pixels.
REQ-017 SHALL have port done_out  output  1  one-cycle pulse at the end of reporting.
REQ-018 SHALL have port num_blobs_out  output  8  count of blobs reported in the last frame.
REQ-019 SHALL have port overflow_out  output  1  last frame contained label >= MAX_LABELS.

Function
REQ-020 SHALL implement states ACCUM, SCAN, EMIT, DONE; reset state ACCUM.
REQ-021 In ACCUM, each valid_in with 0 < label_in < MAX_LABELS SHALL update that entry at the next edge: area+1, min/max x/y, sumx+=x_in, sumy+=y_in; the first pixel of an entry sets min=max=coordinate.
REQ-022 Back-to-back pixels with the same label SHALL each be counted, with no stall.
REQ-023 label_in==0 SHALL be ignored; label_in >= MAX_LABELS SHALL be dropped and set an internal sticky overflow flag.
REQ-024 area SHALL saturate at 2^17-1; the sums SHALL NOT wrap for a 320x180 frame.
REQ-025 frame_done_in in ACCUM SHALL move to SCAN at the next edge with index=1; a valid_in pixel in the same cycle SHALL be accumulated first.
REQ-026 In SCAN, each cycle SHALL test entry[index]: if area >= MIN_AREA, go to EMIT; else index+1; after index MAX_LABELS-1, go to DONE.
REQ-027 In EMIT, blob_valid_out SHALL be 1 and every blob_* output SHALL hold stable until blob_valid_out && blob_ready_in.
REQ-028 On the handshake, the block SHALL increment the reported count, increment index, and return to SCAN, or go to DONE if index was MAX_LABELS-1.
REQ-029 In DONE, for one cycle, the block SHALL:
- pulse done_out;
- load num_blobs_out with the count;
- load overflow_out with the sticky flag;
- clear all entries, count and the flag;
- return to ACCUM.
REQ-030 num_blobs_out and overflow_out SHALL hold until the next DONE.
REQ-031 busy_out SHALL be 0 only in ACCUM; valid_in outside ACCUM SHALL be ignored.
REQ-032 frame_done_in outside ACCUM SHALL be ignored.
REQ-033 A frame with no qualifying blob SHALL go SCAN->DONE with no blob_valid_out, and num_blobs_out SHALL be 0.
REQ-034 Latency from frame_done_in to the first blob_valid_out SHALL equal 1 + (index of the first qualifying label) cycles.

Reset
REQ-035 Assertion of rst_n_in at any time, including mid-EMIT, SHALL immediately:
- force state ACCUM;
- clear all table entries, index, count and the sticky flag;
- drive every output to 0.
REQ-036 Deassertion SHALL be synchronised externally; the first accepted pixel is on the first edge after release.

Verification
REQ-037 60 pixels of label 3 in a 10x6 box at (100..109, 20..25), then frame_done_in with blob_ready_in=1 -> one record: label 3, area 60, x 100..109, y 20..25, sumx 6270, sumy 1350; then done_out with num_blobs_out=1.
REQ-038 Labels 2 (area 49) and 5 (area 50) -> only label 5 is reported; num_blobs_out=1.
REQ-039 Two qualifying blobs with blob_ready_in held 0 for 10 cycles -> the first record is held stable for 10 cycles, then both records arrive in label order.
REQ-040 A pixel with label 20, then frame_done_in -> overflow_out=1 and num_blobs_out=0 after done_out; the next frame without overflow -> overflow_out=0.
REQ-041 rst_n_in pulsed low during EMIT -> blob_valid_out drops at once; the next frame of 55 label-1 pixels reports area 55 only.
REQ-042 The last pixel and frame_done_in in the same cycle -> that pixel is included in the area; pixels driven while busy_out=1 are not counted.
